// File: rtl/cam_alloc_ctrl_pkg.sv
// Shared defaults for the CAM allocation controller.
// Every width inside the block is derived from these parameters.
package cam_alloc_ctrl_pkg;
    localparam int DEFAULT_NUM_ENTRIES = 4;
    localparam int DEFAULT_KEY_WIDTH   = 32;
endpackage

// File: rtl/oh_to_idx.sv
// One-hot to binary index encoder.
// An all-zero input encodes to index 0.
module oh_to_idx #(
    parameter int NUM_ENTRIES = 4,
    parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] oh,
    output logic [INDEX_WIDTH-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (oh[i]) idx = idx | INDEX_WIDTH'(i);
        end
    end
endmodule

// File: rtl/cam_alloc_ctrl.sv
// Allocation controller for an external CAM: picks insert slots (hit, free, round-robin victim),
// removes keys on invalidate, and walks every entry on flush.
module cam_alloc_ctrl
    import cam_alloc_ctrl_pkg::*;
#(
    parameter int NUM_ENTRIES = DEFAULT_NUM_ENTRIES,
    parameter int KEY_WIDTH   = DEFAULT_KEY_WIDTH,
    parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   insert_en,
    input  logic [KEY_WIDTH-1:0]   insert_key,
    output logic                   insert_ready,
    input  logic                   invalidate_en,
    input  logic [KEY_WIDTH-1:0]   invalidate_key,
    output logic                   invalidate_ready,
    input  logic                   flush_en,
    output logic                   busy,
    output logic                   done_valid,
    output logic [INDEX_WIDTH-1:0] done_idx,
    output logic                   done_hit,
    output logic                   flush_done,
    output logic [KEY_WIDTH-1:0]   cam_lookup_key,
    input  logic                   cam_lookup_hit,
    input  logic [INDEX_WIDTH-1:0] cam_lookup_idx,
    output logic                   cam_update_en,
    output logic [KEY_WIDTH-1:0]   cam_update_key,
    output logic [INDEX_WIDTH-1:0] cam_update_idx,
    output logic                   cam_update_valid
);
    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                 state, state_nxt;
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [INDEX_WIDTH-1:0] victim_q, flush_cnt_q;
    logic [NUM_ENTRIES-1:0] free_oh;
    logic [INDEX_WIDTH-1:0] free_idx, ins_idx;
    logic                   idle, any_free, ins_acc, inv_acc, flush_acc, evict, flush_last;

    // Gating with reset keeps the update port quiet while reset is held.
    assign idle             = (state == IDLE) && !reset;
    assign busy             = (state == FLUSH);
    assign invalidate_ready = idle && !flush_en;
    assign insert_ready     = invalidate_ready && !invalidate_en;
    assign inv_acc          = invalidate_en && invalidate_ready;
    assign ins_acc          = insert_en && insert_ready;
    assign flush_acc        = flush_en && idle;
    assign flush_last       = busy && (flush_cnt_q == INDEX_WIDTH'(NUM_ENTRIES - 1));

    assign cam_lookup_key = invalidate_en ? invalidate_key : insert_key;

    // Lowest clear valid bit, isolated as a one-hot vector.
    assign free_oh  = ~valid_q & (valid_q + NUM_ENTRIES'(1));
    assign any_free = ~&valid_q;

    oh_to_idx #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_free_enc (
        .oh (free_oh),
        .idx(free_idx)
    );

    assign ins_idx = cam_lookup_hit ? cam_lookup_idx : (any_free ? free_idx : victim_q);
    assign evict   = ins_acc && !cam_lookup_hit && !any_free;

    always_comb begin
        state_nxt        = state;
        cam_update_en    = 1'b0;
        cam_update_key   = '0;
        cam_update_idx   = '0;
        cam_update_valid = 1'b0;
        if (busy && !reset) begin
            cam_update_en  = 1'b1;
            cam_update_idx = flush_cnt_q;
            if (flush_last) state_nxt = IDLE;
        end else if (flush_acc) begin
            state_nxt = FLUSH;
        end else if (inv_acc) begin
            cam_update_en  = cam_lookup_hit;
            cam_update_key = invalidate_key;
            cam_update_idx = cam_lookup_idx;
        end else if (ins_acc) begin
            cam_update_en    = 1'b1;
            cam_update_key   = insert_key;
            cam_update_idx   = ins_idx;
            cam_update_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            valid_q     <= '0;
            victim_q    <= '0;
            flush_cnt_q <= '0;
            flush_done  <= 1'b0;
            done_valid  <= 1'b0;
            done_idx    <= '0;
            done_hit    <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= flush_last;
            if (cam_update_en) valid_q[cam_update_idx] <= cam_update_valid;
            flush_cnt_q <= busy ? flush_cnt_q + INDEX_WIDTH'(1) : '0;
            if (flush_last) victim_q <= '0;
            else if (evict) victim_q <= victim_q + INDEX_WIDTH'(1);
            done_valid <= ins_acc || inv_acc;
            done_hit   <= (ins_acc || inv_acc) && cam_lookup_hit;
            if (inv_acc) done_idx <= cam_lookup_hit ? cam_lookup_idx : '0;
            else if (ins_acc) done_idx <= ins_idx;
            else done_idx <= '0;
        end
    end
endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Bench for cam_alloc_ctrl: behavioural CAM plus a table-level reference model of allocation.
module tb_cam_alloc_ctrl;
    logic        clk = 0, reset = 0;
    logic        insert_en = 0, invalidate_en = 0, flush_en = 0;
    logic [31:0] insert_key = 0, invalidate_key = 0;
    logic        insert_ready, invalidate_ready, busy, done_valid, done_hit, flush_done;
    logic [1:0]  done_idx, cam_lookup_idx, cam_update_idx;
    logic [31:0] cam_lookup_key, cam_update_key;
    logic        cam_lookup_hit, cam_update_en, cam_update_valid;

    int n_tests = 0, n_fail = 0;

    // Behavioural CAM, cleared together with the controller.
    logic [31:0] cam_key [4];
    logic        cam_vld [4];

    // Reference model: key table, valid flags, round-robin victim.
    logic [31:0] ref_key [4];
    bit          ref_vld [4];
    int          ref_victim;

    always #5 clk = ~clk;

    cam_alloc_ctrl #(.NUM_ENTRIES(4), .KEY_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .insert_en(insert_en), .insert_key(insert_key), .insert_ready(insert_ready),
        .invalidate_en(invalidate_en), .invalidate_key(invalidate_key),
        .invalidate_ready(invalidate_ready),
        .flush_en(flush_en), .busy(busy),
        .done_valid(done_valid), .done_idx(done_idx), .done_hit(done_hit),
        .flush_done(flush_done),
        .cam_lookup_key(cam_lookup_key), .cam_lookup_hit(cam_lookup_hit),
        .cam_lookup_idx(cam_lookup_idx),
        .cam_update_en(cam_update_en), .cam_update_key(cam_update_key),
        .cam_update_idx(cam_update_idx), .cam_update_valid(cam_update_valid)
    );

    always_comb begin
        cam_lookup_hit = 1'b0;
        cam_lookup_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (cam_vld[i] && cam_key[i] == cam_lookup_key) begin
                cam_lookup_hit = 1'b1;
                cam_lookup_idx = 2'(i);
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin cam_vld[i] <= 1'b0; cam_key[i] <= 32'h0; end
        end else if (cam_update_en) begin
            cam_key[cam_update_idx] <= cam_update_key;
            cam_vld[cam_update_idx] <= cam_update_valid;
        end
    end

    task automatic ref_clear();
        for (int i = 0; i < 4; i++) begin ref_vld[i] = 0; ref_key[i] = 0; end
        ref_victim = 0;
    endtask

    task automatic ref_insert(input logic [31:0] k, output logic [1:0] idx, output logic hit);
        int h = -1, f = -1;
        for (int i = 3; i >= 0; i--) begin
            if (ref_vld[i] && ref_key[i] == k) h = i;
            if (!ref_vld[i]) f = i;
        end
        hit = (h >= 0);
        if (h >= 0) idx = 2'(h);
        else if (f >= 0) idx = 2'(f);
        else begin idx = 2'(ref_victim); ref_victim = (ref_victim + 1) % 4; end
        ref_key[idx] = k;
        ref_vld[idx] = 1;
    endtask

    task automatic ref_invalidate(input logic [31:0] k, output logic [1:0] idx, output logic hit);
        hit = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (ref_vld[i] && ref_key[i] == k) begin hit = 1; idx = 2'(i); end
        end
        if (hit) ref_vld[idx] = 0;
    endtask

    // Drive one request for a cycle; capture the same-cycle write and the next-cycle done.
    task automatic drive_op(input bit inv, input logic [31:0] k, output logic rdy,
                            output logic wen, output logic [1:0] widx, output logic wval,
                            output logic [31:0] wkey, output logic dv, output logic [1:0] di,
                            output logic dh);
        @(negedge clk);
        if (inv) begin invalidate_en = 1; invalidate_key = k; end
        else begin insert_en = 1; insert_key = k; end
        #1;
        rdy = inv ? invalidate_ready : insert_ready;
        wen = cam_update_en; widx = cam_update_idx; wval = cam_update_valid; wkey = cam_update_key;
        @(posedge clk); #1;
        insert_en = 0; invalidate_en = 0;
        dv = done_valid; di = done_idx; dh = done_hit;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1; insert_en = 1; insert_key = 32'h5;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({busy, done_valid, flush_done, cam_update_en} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy/dv/fd/upd=%b required 0000",
                     {busy, done_valid, flush_done, cam_update_en});
        end
        insert_en = 0;
        @(negedge clk) reset = 0;
        ref_clear();
    endtask

    task automatic test_fill();
        logic rdy, wen, wval, dv, dh, eh; logic [1:0] widx, di, ei; logic [31:0] wkey, k;
        for (int i = 0; i < 4; i++) begin
            k = 32'h10 * (i + 1);
            drive_op(0, k, rdy, wen, widx, wval, wkey, dv, di, dh);
            ref_insert(k, ei, eh);
            n_tests++;
            if ({rdy, wen, widx, wval, wkey, dv, di, dh} !==
                {1'b1, 1'b1, 2'(i), 1'b1, k, 1'b1, 2'(i), 1'b0}) begin
                n_fail++;
                $display("FAIL fill_%0d: rdy=%b wen=%b idx=%0d val=%b key=%h dv=%b di=%0d dh=%b required idx %0d hit 0",
                         i, rdy, wen, widx, wval, wkey, dv, di, dh, i);
            end
        end
    endtask

    task automatic test_insert_hit();
        logic rdy, wen, wval, dv, dh, eh; logic [1:0] widx, di, ei; logic [31:0] wkey;
        drive_op(0, 32'h20, rdy, wen, widx, wval, wkey, dv, di, dh);
        ref_insert(32'h20, ei, eh);
        n_tests++;
        if ({wen, widx, wval, dv, di, dh} !== {1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL insert_hit: wen=%b idx=%0d val=%b dv=%b di=%0d dh=%b required idx 1 hit 1",
                     wen, widx, wval, dv, di, dh);
        end
    endtask

    task automatic test_evict();
        logic rdy, wen, wval, dv, dh, eh; logic [1:0] widx, di, ei; logic [31:0] wkey, k;
        for (int i = 0; i < 2; i++) begin
            k = (i == 0) ? 32'h50 : 32'h60;
            drive_op(0, k, rdy, wen, widx, wval, wkey, dv, di, dh);
            ref_insert(k, ei, eh);
            n_tests++;
            if ({wen, widx, dv, di, dh} !== {1'b1, 2'(i), 1'b1, 2'(i), 1'b0}) begin
                n_fail++;
                $display("FAIL evict_%h: wen=%b idx=%0d di=%0d dh=%b required idx %0d hit 0",
                         k, wen, widx, di, dh, i);
            end
        end
        drive_op(1, 32'h10, rdy, wen, widx, wval, wkey, dv, di, dh);
        ref_invalidate(32'h10, ei, eh);
        n_tests++;
        if ({rdy, wen, dv, di, dh} !== {1'b1, 1'b0, 1'b1, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL evicted_key_miss: rdy=%b wen=%b dv=%b di=%0d dh=%b required no write, hit 0",
                     rdy, wen, dv, di, dh);
        end
    endtask

    task automatic test_invalidate();
        logic rdy, wen, wval, dv, dh, eh; logic [1:0] widx, di, ei; logic [31:0] wkey;
        drive_op(1, 32'h30, rdy, wen, widx, wval, wkey, dv, di, dh);
        ref_invalidate(32'h30, ei, eh);
        n_tests++;
        if ({wen, widx, wval, dv, di, dh} !== {1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL inval_hit: wen=%b idx=%0d val=%b di=%0d dh=%b required idx 2 val 0 hit 1",
                     wen, widx, wval, di, dh);
        end
        drive_op(0, 32'h70, rdy, wen, widx, wval, wkey, dv, di, dh);
        ref_insert(32'h70, ei, eh);
        n_tests++;
        if ({wen, widx, di, dh} !== {1'b1, 2'd2, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL refill_free: wen=%b idx=%0d di=%0d dh=%b required idx 2", wen, widx, di, dh);
        end
        // Victim was 2 before the refill; an unchanged pointer evicts idx 2 next.
        drive_op(0, 32'h80, rdy, wen, widx, wval, wkey, dv, di, dh);
        ref_insert(32'h80, ei, eh);
        n_tests++;
        if ({wen, widx, di} !== {1'b1, 2'd2, 2'd2}) begin
            n_fail++;
            $display("FAIL victim_unchanged: idx=%0d di=%0d required 2", widx, di);
        end
        drive_op(1, 32'h99, rdy, wen, widx, wval, wkey, dv, di, dh);
        ref_invalidate(32'h99, ei, eh);
        n_tests++;
        if ({wen, dv, di, dh} !== {1'b0, 1'b1, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL inval_miss: wen=%b dv=%b di=%0d dh=%b required no write, idx 0 hit 0",
                     wen, dv, di, dh);
        end
    endtask

    task automatic test_flush_with_insert();
        logic [1:0] ei; logic eh;
        @(negedge clk);
        flush_en = 1; insert_en = 1; insert_key = 32'hA0;
        #1;
        n_tests++;
        if ({insert_ready, cam_update_en, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_accept: ready=%b upd=%b busy=%b required 000",
                     insert_ready, cam_update_en, busy);
        end
        @(posedge clk); #1;
        flush_en = 0;
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if ({busy, insert_ready, cam_update_en, cam_update_idx, cam_update_valid, cam_update_key,
                 flush_done} !== {1'b1, 1'b0, 1'b1, 2'(c), 1'b0, 32'h0, 1'b0}) begin
                n_fail++;
                $display("FAIL flush_cycle_%0d: busy=%b rdy=%b upd=%b idx=%0d val=%b key=%h fd=%b",
                         c, busy, insert_ready, cam_update_en, cam_update_idx, cam_update_valid,
                         cam_update_key, flush_done);
            end
            @(posedge clk); #1;
        end
        ref_clear();
        ref_insert(32'hA0, ei, eh);
        n_tests++;
        if ({flush_done, busy, insert_ready, cam_update_en, cam_update_idx, cam_update_valid} !==
            {1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_end: fd=%b busy=%b rdy=%b upd=%b idx=%0d val=%b required fd 1, insert at 0",
                     flush_done, busy, insert_ready, cam_update_en, cam_update_idx, cam_update_valid);
        end
        @(posedge clk); #1;
        insert_en = 0;
        n_tests++;
        if ({done_valid, done_idx, done_hit, flush_done} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL held_insert_done: dv=%b di=%0d dh=%b fd=%b required dv 1 idx 0",
                     done_valid, done_idx, done_hit, flush_done);
        end
    endtask

    task automatic test_reset_during_flush();
        logic rdy, wen, wval, dv, dh, eh; logic [1:0] widx, di, ei; logic [31:0] wkey, k;
        int fd_seen = 0;
        @(negedge clk) flush_en = 1;
        @(posedge clk); #1;
        flush_en = 0;
        @(posedge clk); #1;
        reset = 1;
        #1;
        n_tests++;
        if ({busy, cam_update_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_abort: busy=%b upd=%b required 00", busy, cam_update_en);
        end
        @(negedge clk) reset = 0;
        ref_clear();
        repeat (5) begin
            @(posedge clk); #1;
            if (flush_done) fd_seen++;
        end
        n_tests++;
        if (fd_seen != 0) begin
            n_fail++;
            $display("FAIL aborted_flush_done: %0d pulses seen, required 0", fd_seen);
        end
        for (int i = 0; i < 4; i++) begin
            k = 32'hC0 + 32'(i);
            drive_op(0, k, rdy, wen, widx, wval, wkey, dv, di, dh);
            ref_insert(k, ei, eh);
            n_tests++;
            if ({wen, widx, di, dh} !== {1'b1, 2'(i), 2'(i), 1'b0}) begin
                n_fail++;
                $display("FAIL post_reset_fill_%0d: idx=%0d di=%0d dh=%b required idx %0d hit 0",
                         i, widx, di, dh, i);
            end
        end
    endtask

    task automatic test_random();
        logic rdy, wen, wval, dv, dh, eh; logic [1:0] widx, di, ei; logic [31:0] wkey, k;
        int r, bad;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 11);
            k = 32'h100 + 32'($urandom_range(0, 5));
            if (r == 0) begin
                bad = 0;
                @(negedge clk) flush_en = 1;
                @(posedge clk); #1;
                flush_en = 0;
                for (int c = 0; c < 4; c++) begin
                    if ({busy, cam_update_en, cam_update_idx, cam_update_valid} !==
                        {1'b1, 1'b1, 2'(c), 1'b0}) bad++;
                    @(posedge clk); #1;
                end
                ref_clear();
                n_tests++;
                if (bad != 0 || flush_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_flush_%0d: %0d bad write cycles, fd=%b required 0 and 1",
                             n, bad, flush_done);
                end
            end else if (r < 5) begin
                drive_op(1, k, rdy, wen, widx, wval, wkey, dv, di, dh);
                ref_invalidate(k, ei, eh);
                n_tests++;
                if ({rdy, wen, dv, di, dh} !== {1'b1, eh, 1'b1, ei, eh} ||
                    (eh && {widx, wval} !== {ei, 1'b0})) begin
                    n_fail++;
                    $display("FAIL rand_inval_%0d key=%h: wen=%b idx=%0d val=%b di=%0d dh=%b required wen %b idx %0d hit %b",
                             n, k, wen, widx, wval, di, dh, eh, ei, eh);
                end
            end else begin
                drive_op(0, k, rdy, wen, widx, wval, wkey, dv, di, dh);
                ref_insert(k, ei, eh);
                n_tests++;
                if ({rdy, wen, widx, wval, wkey, dv, di, dh} !==
                    {1'b1, 1'b1, ei, 1'b1, k, 1'b1, ei, eh}) begin
                    n_fail++;
                    $display("FAIL rand_insert_%0d key=%h: wen=%b idx=%0d val=%b di=%0d dh=%b required idx %0d hit %b",
                             n, k, wen, widx, wval, di, dh, ei, eh);
                end
            end
        end
    endtask

    initial begin
        ref_clear();
        test_reset();
        test_fill();
        test_insert_hit();
        test_evict();
        test_invalidate();
        test_flush_with_insert();
        test_reset_during_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cam_alloc_ctrl.md
CAM_ALLOC_CTRL -- requirements
Module: cam_alloc_ctrl

Interface
REQ-001 Parameter NUM_ENTRIES, default 4: number of entries in the controlled cam; SHALL be a power of two, at least 2.
REQ-002 Parameter KEY_WIDTH, default 32: key width; SHALL match the controlled cam.
REQ-003 Parameter INDEX_WIDTH, default $clog2(NUM_ENTRIES): entry index width.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 insert_en  in  1  request to install insert_key; accepted only when insert_ready is high.
REQ-007 insert_key  in  KEY_WIDTH  key to install.
REQ-008 insert_ready  out  1  controller can accept an insert this cycle.
REQ-009 invalidate_en  in  1  request to remove invalidate_key; accepted only when invalidate_ready is high.
REQ-010 invalidate_key  in  KEY_WIDTH  key to remove.
REQ-011 invalidate_ready  out  1  controller can accept an invalidate this cycle.
REQ-012 flush_en  in  1  request to invalidate all entries; ignored while busy.
REQ-013 busy  out  1  flush sequence in progress.
REQ-014 done_valid  out  1  one-cycle pulse: the previous accepted insert or invalidate completed.
REQ-015 done_idx  out  INDEX_WIDTH  entry written by the completed operation.
REQ-016 done_hit  out  1  the key was already present, for insert or invalidate.
REQ-017 flush_done  out  1  one-cycle pulse after the last flush write.
REQ-018 cam_lookup_key  out  KEY_WIDTH  drives the cam lookup port.
REQ-019 cam_lookup_hit  in  1  cam hit result, asynchronous, same cycle.
REQ-020 cam_lookup_idx  in  INDEX_WIDTH  cam hit index.
REQ-021 cam_update_en / cam_update_key / cam_update_idx / cam_update_valid  out  1 / KEY_WIDTH / INDEX_WIDTH / 1  drive the cam update port.

Function
REQ-022 States SHALL be IDLE and FLUSH. busy SHALL equal (state == FLUSH).
REQ-023 Priority in IDLE SHALL be flush_en, then invalidate_en, then insert_en. invalidate_ready = IDLE && !flush_en. insert_ready = IDLE && !flush_en && !invalidate_en.
REQ-024 cam_lookup_key SHALL combinationally select invalidate_key when invalidate_en is set, and insert_key otherwise.
REQ-025 An accepted insert SHALL assert cam_update_en in the same cycle with cam_update_valid = 1 and cam_update_key = insert_key. The target index SHALL be chosen as follows:
- the cam hit index on a hit;
- otherwise the lowest-numbered entry whose local valid bit is clear;
- otherwise the round-robin victim pointer.
REQ-026 The victim pointer SHALL advance by 1, wrapping from NUM_ENTRIES-1 to 0, only when it is used for an eviction.
REQ-027 An accepted invalidate that hits SHALL write cam_update_valid = 0 at the hit index. On a miss, no cam write SHALL occur; done_hit = 0 and done_idx = 0.
REQ-028 The controller SHALL keep a local valid-bit vector that mirrors every cam write it issues.
REQ-029 done_valid, done_idx and done_hit SHALL be registered and asserted on the cycle after acceptance (latency 1).
REQ-030 Accepted flush_en SHALL enter FLUSH with counter 0. Each FLUSH cycle SHALL:
- write cam_update_valid = 0 and cam_update_key = 0 at the counter;
- clear the matching local valid bit;
- increment the counter.
REQ-031 After writing entry NUM_ENTRIES-1, the controller SHALL return to IDLE, pulse flush_done on the next cycle, and reset the victim pointer to 0. A flush therefore occupies NUM_ENTRIES busy cycles.
REQ-032 cam_update_en SHALL never be asserted in a cycle with no accepted request and outside FLUSH. Inputs outside the ready window SHALL be ignored without side effects.
REQ-033 The controller SHALL never create a duplicate key in the cam, because inserts that hit reuse the hit index.

Reset
REQ-034 While reset is asserted, the following SHALL be held low: every output pulse, cam_update_en, busy, and the local valid bits. The victim pointer and flush counter SHALL be 0 and state SHALL be IDLE.
REQ-035 Reset during FLUSH SHALL abort the sequence immediately, with no flush_done.

Structure
REQ-036 No new shared-package types are needed. The state enum is local to the module; all widths derive from the parameters.
REQ-037 The free-entry search SHALL isolate the lowest clear valid bit as a one-hot vector and encode it with the existing oh_to_idx sub-module.

Verification
REQ-038 Fill an empty controller (NUM_ENTRIES=4) with keys 0x10, 0x20, 0x30, 0x40 -> done_idx 0, 1, 2, 3, all with done_hit 0.
REQ-039 Table full, then insert 0x50 and 0x60 -> evictions at idx 0 then idx 1. A later lookup of 0x10 misses.
REQ-040 Insert 0x20 when it is already present at idx 1 -> done_idx 1, done_hit 1, no other entry written.
REQ-041 Invalidate 0x30 (hit, idx 2), then insert 0x70 -> 0x70 fills idx 2 and the victim pointer is unchanged. Invalidate of an absent key 0x99 -> no cam write, done_hit 0.
REQ-042 flush_en with insert_en held in the same cycle:
- busy for 4 cycles, insert_ready low throughout;
- cam writes to idx 0, 1, 2, 3 with valid 0, then flush_done;
- the held insert is accepted on the next cycle and placed at idx 0.
REQ-043 Assert reset in the second FLUSH cycle -> busy falls immediately, no flush_done, all local valid bits 0.
